// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  // Sequencer states; kept as plain constants so older tools can consume them.
  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StMul  = 2'd1;
  localparam state_t StDiv  = 2'd2;
  localparam state_t StFix  = 2'd3;

  // One result bit per iteration of a 32-bit operand.
  localparam int unsigned ITER_COUNT = 32;

  // LO value written when the divisor is zero.
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Magnitude of a 32-bit operand; only folds negatives for signed operations.
  // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the sequential multiply (shift-add) or restoring divide.
// The 64-bit accumulator holds {upper, lower}:
//   multiply: upper = partial product, lower = remaining multiplier bits
//   divide:   upper = partial remainder, lower = dividend bits / quotient bits
module muldiv_iter_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,     // multiplicand or divisor magnitude
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] trial;
  logic [32:0] diff;

  // Combinational step: add-and-shift right, or shift-left-and-trial-subtract.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, opnd};
    // Remainder shifted left by one with the next dividend bit brought in.
    trial    = acc[63:31];
    diff     = trial - {1'b0, opnd};
    acc_next = acc;
    if (is_div) begin
      // Remainder stays below the divisor, so a clear borrow bit means trial >= divisor.
      if (!diff[32]) begin
        acc_next = {diff[31:0], acc[30:0], 1'b1};
      end else begin
        acc_next = {trial[31:0], acc[30:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum, acc[31:1]};
    end else begin
      acc_next = {1'b0, acc[63:32], acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Operands are captured as magnitudes; sign correction happens in the FIX state
// and results are committed to HI/LO on the FIX->IDLE edge together with done.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_ena,
  input  logic        div_ena,
  input  logic        op_sign,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        hilo_read,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero
);

  localparam logic [5:0] LastIter = 6'(ITER_COUNT - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        is_div_q;
  logic        sign_q;
  logic        rs_neg_q;
  logic        rt_neg_q;
  logic        dz_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q, dz_pulse_q;

  logic        start_mul, start_div, start_dz;
  logic        iterating, finish;
  logic [63:0] acc_next;
  logic        neg_result, neg_rem;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic [31:0] fix_hi, fix_lo;

  // Next-state decode; a flush in IDLE blocks any start in the same cycle.
  always_comb begin
    state_d   = state_q;
    start_mul = 1'b0;
    start_div = 1'b0;
    start_dz  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!flush) begin
          if (div_ena) begin
            start_div = 1'b1;
            if (rt_data == 32'd0) begin
              start_dz = 1'b1;
              state_d  = StFix;
            end else begin
              state_d = StDiv;
            end
          end else if (mul_ena) begin
            start_mul = 1'b1;
            state_d   = StMul;
          end
        end
      end
      StMul, StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign iterating = (state_q == StMul) || (state_q == StDiv);
  assign finish    = (state_q == StFix) && !flush;

  muldiv_iter_step u_iter_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_next)
  );

  // Sign correction of the finished magnitude result.
  always_comb begin
    neg_result = sign_q && (rs_neg_q ^ rt_neg_q);
    neg_rem    = sign_q && rs_neg_q;
    prod       = neg_result ? (~acc_q + 64'd1) : acc_q;
    quo        = neg_result ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem        = neg_rem ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    fix_hi     = prod[63:32];
    fix_lo     = prod[31:0];
    if (dz_q) begin
      // Divide-by-zero result was preloaded into the accumulator at start.
      fix_hi = acc_q[63:32];
      fix_lo = acc_q[31:0];
    end else if (is_div_q) begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, iteration counter and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start_mul || start_div) begin
      cnt_q    <= 6'd0;
      is_div_q <= start_div;
      sign_q   <= op_sign;
      rs_neg_q <= rs_data[31];
      rt_neg_q <= rt_data[31];
      dz_q     <= start_dz;
      if (start_dz) begin
        acc_q  <= {rs_data, DIV_ZERO_LO};
        opnd_q <= 32'd0;
      end else if (start_div) begin
        acc_q  <= {32'd0, abs32(rs_data, op_sign)};
        opnd_q <= abs32(rt_data, op_sign);
      end else begin
        acc_q  <= {32'd0, abs32(rt_data, op_sign)};
        opnd_q <= abs32(rs_data, op_sign);
      end
    end else if (iterating && !flush) begin
      acc_q <= acc_next;
      // Saturates at ITER_COUNT on the edge that enters FIX.
      cnt_q <= cnt_q + 6'd1;
    end else if (state_q != StIdle) begin
      // Leaving via flush or FIX: counter parks at zero.
      cnt_q <= 6'd0;
    end
  end

  // HI/LO: commit on completion, otherwise direct moves only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (finish) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (state_q == StIdle) begin
      if (mthi) begin
        hi_q <= rs_data;
      end
      if (mtlo) begin
        lo_q <= rs_data;
      end
    end
  end

  // Single-cycle completion pulses, suppressed by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      done_q     <= finish;
      dz_pulse_q <= finish && dz_q;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != StIdle);
  assign stall    = busy && (mul_ena || div_ena || mthi || mtlo || hilo_read);
  assign done     = done_q;
  assign div_zero = dz_pulse_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: table of operations checked through
// a scoreboard queue, plus hand sequences for stall, flush and reset corners.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_ena, div_ena, op_sign;
  logic [31:0] rs_data, rt_data;
  logic        mthi, mtlo, hilo_read, flush;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_div;
    logic        both;     // assert mul_ena too (div must win)
    logic        sgn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  localparam int NumVec = 13;
  vec_t vecs[NumVec];
  vec_t sb[$];

  muldiv_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .mul_ena   (mul_ena),
    .div_ena   (div_ena),
    .op_sign   (op_sign),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hilo_read (hilo_read),
    .flush     (flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic is_div, input logic both, input logic sgn,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] eh, input logic [31:0] el,
                              input logic dz, input int lat);
    vec_t v;
    v.is_div = is_div; v.both = both; v.sgn = sgn; v.rs = rs; v.rt = rt;
    v.exp_hi = eh; v.exp_lo = el; v.exp_dz = dz; v.exp_lat = lat;
    return v;
  endfunction

  // Start an op, push its expectation, count edges to done, pop and compare.
  task automatic run_op(input vec_t v, input int idx);
    vec_t e;
    int   lat;
    @(negedge clk);
    div_ena = v.is_div;
    mul_ena = !v.is_div || v.both;
    op_sign = v.sgn;
    rs_data = v.rs;
    rt_data = v.rt;
    sb.push_back(v);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        // Operands must already be latched; scramble them.
        mul_ena = 1'b0;
        div_ena = 1'b0;
        op_sign = !v.sgn;
        rs_data = $urandom;
        rt_data = $urandom;
      end
    end while (!done && lat < 100);
    e = sb.pop_front();
    check($sformatf("v%0d done_seen", idx), 64'(done), 64'd1);
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(e.exp_lat));
    check($sformatf("v%0d hi", idx), 64'(hi), 64'(e.exp_hi));
    check($sformatf("v%0d lo", idx), 64'(lo), 64'(e.exp_lo));
    check($sformatf("v%0d div_zero", idx), 64'(div_zero), 64'(e.exp_dz));
    check($sformatf("v%0d busy_at_done", idx), 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    logic seen;

    //             div both sgn rs             rt             hi             lo             dz lat
    vecs[0]  = mk(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 34);
    vecs[1]  = mk(0, 0, 1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 34);
    vecs[2]  = mk(0, 0, 0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 0, 34);
    vecs[3]  = mk(0, 0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 34);
    vecs[4]  = mk(1, 0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34);
    vecs[5]  = mk(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 34);
    vecs[6]  = mk(1, 0, 0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1, 2);
    vecs[7]  = mk(1, 0, 0, 32'd100,       32'd7,         32'd2,         32'd14,        0, 34);
    vecs[8]  = mk(1, 0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 0, 34);
    vecs[9]  = mk(1, 0, 1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 34);
    vecs[10] = mk(1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0, 34);
    vecs[11] = mk(1, 0, 1, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1, 2);
    vecs[12] = mk(1, 1, 0, 32'd20,        32'd3,         32'd2,         32'd6,         0, 34);

    rst = 1'b1;
    mul_ena = 0; div_ena = 0; op_sign = 0; rs_data = 0; rt_data = 0;
    mthi = 0; mtlo = 0; hilo_read = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      run_op(vecs[i], i);
    end

    // Direct HI/LO writes in IDLE.
    @(negedge clk);
    mthi = 1; rs_data = 32'h0000_1234;
    @(negedge clk);
    mthi = 0; mtlo = 1; rs_data = 32'h0000_5678;
    @(negedge clk);
    mtlo = 0; rs_data = 32'hDEAD_BEEF;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mtlo lo", 64'(lo), 64'h5678);

    // Flush a multiply at iteration 10.
    mul_ena = 1; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge clk);
    #1;
    mul_ena = 0;
    check("flush busy_after_start", 64'(busy), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'h1234);
    check("flush lo", 64'(lo), 64'h5678);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1;
      @(posedge clk);
      #1;
    end
    check("flush no_done", 64'(seen), 64'd0);
    check("flush hi_later", 64'(hi), 64'h1234);

    // Flush together with a start while idle: nothing starts.
    @(negedge clk);
    flush = 1; mul_ena = 1; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clk);
    #1;
    flush = 0; mul_ena = 0;
    check("idle_flush no_start", 64'(busy), 64'd0);

    // mflo 3 cycles into a divide: stall until done.
    @(negedge clk);
    div_ena = 1; op_sign = 0; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk);
    #1;
    div_ena = 0;
    repeat (2) @(posedge clk);
    #1;
    hilo_read = 1;
    #1;
    n = 0;
    do begin
      check("stall while busy", 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 100);
    check("stall done_seen", 64'(done), 64'd1);
    check("stall released", 64'(stall), 64'd0);
    check("stall lo", 64'(lo), 64'd14);
    hilo_read = 0;

    // Asynchronous reset mid-divide.
    @(negedge clk);
    div_ena = 1; rs_data = 32'd1000; rt_data = 32'd3;
    @(posedge clk);
    #1;
    div_ena = 0;
    repeat (14) @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("async_rst hi", 64'(hi), 64'd0);
    check("async_rst lo", 64'(lo), 64'd0);
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("async_rst no_done", 64'(seen), 64'd0);
    check("async_rst lo_later", 64'(lo), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
